// File: rtl/axi_rd_req_gen.sv
// Strided 2-D tile read-request generator: walks rows of a tile descriptor and
// emits word-aligned read requests clipped to a maximum burst and to 4 KB pages.
module axi_rd_req_gen #(
    parameter int AXI_DATA_W      = 64,
    parameter int ADDR_W          = 32,
    parameter int TX_SIZE_WIDTH   = 10,
    parameter int MAX_BURST_WORDS = 16,
    parameter int CNT_W           = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_start,
    input  logic [ADDR_W-1:0]        cfg_base_addr,
    input  logic [CNT_W-1:0]         cfg_row_words,
    input  logic [ADDR_W-1:0]        cfg_stride,
    input  logic [CNT_W-1:0]         cfg_num_rows,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_req,
    input  logic                     rd_ready,
    output logic [TX_SIZE_WIDTH-1:0] rd_req_size,
    output logic [ADDR_W-1:0]        rd_addr
);

    localparam int WORD_BYTES = AXI_DATA_W / 8;
    localparam int WB_SHIFT   = $clog2(WORD_BYTES);
    // Chunk arithmetic width: wide enough for a row length, a page's worth of
    // words and the burst limit, so nothing is truncated before the min.
    localparam int CW_A = (CNT_W > TX_SIZE_WIDTH + 1) ? CNT_W : TX_SIZE_WIDTH + 1;
    localparam int CW   = (CW_A > 13) ? CW_A : 13;
    localparam logic [CW-1:0]            MAX_CW = CW'(MAX_BURST_WORDS);
    localparam logic [TX_SIZE_WIDTH-1:0] MAX_TX = TX_SIZE_WIDTH'(MAX_BURST_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Handshake: rd_req is valid; a request transfers on a rising edge where
    // rd_req && rd_ready. While rd_req && !rd_ready, rd_req/rd_addr/rd_req_size
    // hold; rd_req never drops without a transfer except on reset.

    logic [ADDR_W-1:0] row_start, row_start_n;
    logic [ADDR_W-1:0] stride_q, stride_n;
    logic [CNT_W-1:0]  row_words_q, row_words_n;
    logic [CNT_W-1:0]  num_rows_q, num_rows_n;
    logic [CNT_W-1:0]  row_idx, row_idx_n;
    logic [CNT_W-1:0]  row_rem, row_rem_n;
    logic              req_n, busy_n, done_n;
    logic [ADDR_W-1:0] addr_n;
    logic [TX_SIZE_WIDTH-1:0] size_n;

    logic              accept;
    logic [CNT_W-1:0]  rem_after;
    logic [ADDR_W-1:0] addr_after;
    logic [ADDR_W-1:0] next_row_start;
    logic              row_end;
    logic              row_last;

    logic [11:0]       chunk_off;
    logic [CNT_W-1:0]  chunk_rem;
    logic [12:0]       room_bytes;
    logic [CW-1:0]     room_words;
    logic [CW-1:0]     rem_cw;
    logic [CW-1:0]     min_rm;
    logic              rem_le_max;
    logic              room_lt;
    logic [TX_SIZE_WIDTH-1:0] chunk_size;

    assign accept = rd_req && rd_ready;

    // Position after the current request and the operands of the next chunk.
    always_comb begin
        rem_after      = row_rem - CNT_W'(rd_req_size);
        addr_after     = rd_addr + (ADDR_W'(rd_req_size) << WB_SHIFT);
        next_row_start = row_start + stride_q;
        row_end        = (rem_after == '0);
        row_last       = ((row_idx + CNT_W'(1)) == num_rows_q);
        chunk_off      = row_start[11:0];
        chunk_rem      = row_words_q;
        if (state == S_REQ) begin
            if (row_end) begin
                chunk_off = next_row_start[11:0];
            end else begin
                chunk_off = addr_after[11:0];
                chunk_rem = rem_after;
            end
        end
    end

    // Chunk = min(row remainder, burst limit, words left in the 4 KB page).
    always_comb begin
        room_bytes = 13'h1000 - {1'b0, chunk_off};
        room_words = CW'(room_bytes >> WB_SHIFT);
        rem_cw     = CW'(chunk_rem);
        rem_le_max = (rem_cw <= MAX_CW);
        min_rm     = rem_le_max ? rem_cw : MAX_CW;
        room_lt    = (room_words < min_rm);
        if (room_lt) begin
            chunk_size = TX_SIZE_WIDTH'(room_words);
        end else if (rem_le_max) begin
            chunk_size = TX_SIZE_WIDTH'(rem_cw);
        end else begin
            chunk_size = MAX_TX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        row_start_n = row_start;
        stride_n    = stride_q;
        row_words_n = row_words_q;
        num_rows_n  = num_rows_q;
        row_idx_n   = row_idx;
        row_rem_n   = row_rem;
        req_n       = rd_req;
        addr_n      = rd_addr;
        size_n      = rd_req_size;

        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    state_next  = S_CALC;
                    row_start_n = cfg_base_addr;
                    stride_n    = cfg_stride;
                    row_words_n = cfg_row_words;
                    num_rows_n  = cfg_num_rows;
                    row_idx_n   = '0;
                    row_rem_n   = '0;
                end
            end
            S_CALC: begin
                if (num_rows_q == '0 || row_words_q == '0) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_REQ;
                    req_n      = 1'b1;
                    addr_n     = row_start;
                    size_n     = chunk_size;
                    row_rem_n  = row_words_q;
                end
            end
            S_REQ: begin
                if (accept) begin
                    if (row_end && row_last) begin
                        state_next = S_DONE;
                        req_n      = 1'b0;
                    end else if (row_end) begin
                        row_idx_n   = row_idx + CNT_W'(1);
                        row_start_n = next_row_start;
                        row_rem_n   = row_words_q;
                        addr_n      = next_row_start;
                        size_n      = chunk_size;
                    end else begin
                        row_rem_n = rem_after;
                        addr_n    = addr_after;
                        size_n    = chunk_size;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                req_n      = 1'b0;
            end
        endcase

        busy_n = (state_next != S_IDLE);
        done_n = (state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_start   <= '0;
            stride_q    <= '0;
            row_words_q <= '0;
            num_rows_q  <= '0;
            row_idx     <= '0;
            row_rem     <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            rd_req_size <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            row_start   <= row_start_n;
            stride_q    <= stride_n;
            row_words_q <= row_words_n;
            num_rows_q  <= num_rows_n;
            row_idx     <= row_idx_n;
            row_rem     <= row_rem_n;
            rd_req      <= req_n;
            rd_addr     <= addr_n;
            rd_req_size <= size_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        (rd_req && !rd_ready) |=> (rd_req && $stable(rd_addr) && $stable(rd_req_size)));

    a_size_range: assert property (@(posedge clk) disable iff (reset)
        rd_req |-> (rd_req_size != '0 && rd_req_size <= MAX_TX));

    a_done_quiet: assert property (@(posedge clk) disable iff (reset)
        done |-> (!rd_req && busy));

endmodule

// File: tb/tb_axi_rd_req_gen.sv
// Bench for axi_rd_req_gen: scenario tasks drive tile descriptors and compare the
// issued request stream against an expected queue built from the tiling rules.
module tb_axi_rd_req_gen;

    localparam int ADDR_W = 32;
    localparam int TXW    = 10;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              start_a, start_b;
    logic [ADDR_W-1:0] cfg_base_addr, cfg_stride;
    logic [CNT_W-1:0]  cfg_row_words, cfg_num_rows;
    logic              rd_ready;

    logic              busy_a, done_a, req_a;
    logic [TXW-1:0]    size_a;
    logic [ADDR_W-1:0] addr_a;
    logic              busy_b, done_b, req_b;
    logic [TXW-1:0]    size_b;
    logic [ADDR_W-1:0] addr_b;

    logic              sel_b;
    logic              o_busy, o_done, o_req;
    logic [TXW-1:0]    o_size;
    logic [ADDR_W-1:0] o_addr;

    logic [ADDR_W+TXW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    axi_rd_req_gen dut_a (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (start_a),
        .cfg_base_addr (cfg_base_addr),
        .cfg_row_words (cfg_row_words),
        .cfg_stride    (cfg_stride),
        .cfg_num_rows  (cfg_num_rows),
        .busy          (busy_a),
        .done          (done_a),
        .rd_req        (req_a),
        .rd_ready      (rd_ready),
        .rd_req_size   (size_a),
        .rd_addr       (addr_a)
    );

    axi_rd_req_gen #(.MAX_BURST_WORDS(1023)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (start_b),
        .cfg_base_addr (cfg_base_addr),
        .cfg_row_words (cfg_row_words),
        .cfg_stride    (cfg_stride),
        .cfg_num_rows  (cfg_num_rows),
        .busy          (busy_b),
        .done          (done_b),
        .rd_req        (req_b),
        .rd_ready      (rd_ready),
        .rd_req_size   (size_b),
        .rd_addr       (addr_b)
    );

    always_comb begin
        o_busy = sel_b ? busy_b : busy_a;
        o_done = sel_b ? done_b : done_a;
        o_req  = sel_b ? req_b  : req_a;
        o_size = sel_b ? size_b : size_a;
        o_addr = sel_b ? addr_b : addr_a;
    end

    task automatic set_cfg(input logic [31:0] base, input int rw, input logic [31:0] stride, input int rows);
        cfg_base_addr = base;
        cfg_row_words = 16'(rw);
        cfg_stride    = stride;
        cfg_num_rows  = 16'(rows);
    endtask

    // Reference: rows walked in order, each row cut into min(rem, burst, page room) chunks.
    task automatic model_tile(input logic [31:0] base, input int rw, input logic [31:0] stride,
                              input int rows, input int maxb);
        for (int r = 0; r < rows; r++) begin
            logic [31:0] a;
            int rem;
            a   = base + stride * 32'(r);
            rem = rw;
            while (rem > 0) begin
                int room, s;
                room = (4096 - int'(a[11:0])) / 8;
                s = rem;
                if (maxb < s) s = maxb;
                if (room < s) s = room;
                exp_q.push_back({a, 10'(s)});
                a   = a + 32'(s * 8);
                rem = rem - s;
            end
        end
    endtask

    task automatic push_basic();
        exp_q.push_back({32'h0000_1000, 10'd16});
        exp_q.push_back({32'h0000_1080, 10'd16});
        exp_q.push_back({32'h0000_1100, 10'd8});
        exp_q.push_back({32'h0000_1400, 10'd16});
        exp_q.push_back({32'h0000_1480, 10'd16});
        exp_q.push_back({32'h0000_1500, 10'd8});
    endtask

    // Starts the selected DUT, then checks every cycle until done (or until
    // stop_after accepts have been made, leaving the tile running).
    task automatic run_tile(input string name, input int ready_pct, input bit mid_start, input int stop_after);
        int cyc, accepts, first_req;
        bit seen_done, prev_stall, last_acc, expect_empty, stopped;
        logic [ADDR_W-1:0] prev_addr;
        logic [TXW-1:0]    prev_size;
        logic [ADDR_W+TXW-1:0] exp_item;
        accepts = 0; first_req = -1; seen_done = 0; prev_stall = 0; last_acc = 0; stopped = 0;
        prev_addr = '0; prev_size = '0;
        expect_empty = (exp_q.size() == 0);
        @(negedge clk);
        rd_ready = 1'b0;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        cyc = 1;
        while (!seen_done && !stopped && cyc <= 3000) begin
            n_checks++;
            if (o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_high cyc %0d: got %b expected 1", name, cyc, o_busy);
            end
            if (mid_start && cyc == 4) begin
                start_a = 1'b1;
                set_cfg($urandom() & 32'hFFFF_FFF8, 3, 32'h40, 5);
            end
            if (mid_start && cyc == 5) start_a = 1'b0;
            if (o_done === 1'b1) begin
                seen_done = 1;
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL %s done_all_sent: got %0d outstanding expected 0", name, exp_q.size());
                end
                n_checks++;
                if (o_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s done_no_req: got %b expected 0", name, o_req);
                end
                n_checks++;
                if (expect_empty ? (cyc != 2) : !last_acc) begin
                    n_fail++;
                    $display("FAIL %s done_timing: got cycle %0d (last_acc=%b) expected %s",
                             name, cyc, last_acc, expect_empty ? "cycle 2" : "cycle after final accept");
                end
            end else begin
                if (prev_stall) begin
                    n_checks++;
                    if (o_req !== 1'b1 || o_addr !== prev_addr || o_size !== prev_size) begin
                        n_fail++;
                        $display("FAIL %s stall_hold cyc %0d: got req=%b addr=%h size=%0d expected req=1 addr=%h size=%0d",
                                 name, cyc, o_req, o_addr, o_size, prev_addr, prev_size);
                    end
                end
                if (o_req === 1'b1 && first_req < 0) begin
                    first_req = cyc;
                    n_checks++;
                    if (cyc != 2) begin
                        n_fail++;
                        $display("FAIL %s start_latency: got cycle %0d expected cycle 2", name, cyc);
                    end
                end
                if (stop_after > 0 && accepts == stop_after) begin
                    stopped = 1;
                end else begin
                    rd_ready = ($urandom_range(99) < 32'(ready_pct));
                    if (o_req === 1'b1 && rd_ready) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL %s extra_req: got addr=%h size=%0d expected none", name, o_addr, o_size);
                        end else begin
                            exp_item = exp_q.pop_front();
                            if ({o_addr, o_size} !== exp_item) begin
                                n_fail++;
                                $display("FAIL %s req #%0d: got addr=%h size=%0d expected addr=%h size=%0d",
                                         name, accepts, o_addr, o_size, exp_item[ADDR_W+TXW-1:TXW], exp_item[TXW-1:0]);
                            end
                        end
                        accepts++;
                        last_acc   = 1;
                        prev_stall = 0;
                    end else begin
                        last_acc   = 0;
                        prev_stall = (o_req === 1'b1);
                        prev_addr  = o_addr;
                        prev_size  = o_size;
                    end
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        if (!stopped) begin
            if (!seen_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s timeout: got no done in %0d cycles expected done", name, cyc);
            end
            rd_ready = 1'b0;
            @(negedge clk);
            n_checks++;
            if (o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_fall: got %b expected 0", name, o_busy);
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (o_done !== 1'b0 || o_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s quiet_after_done: got done=%b req=%b expected 0 0", name, o_done, o_req);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_a, size_a, addr_a, busy_a, done_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got req=%b size=%0d addr=%h busy=%b done=%b expected all 0",
                     req_a, size_a, addr_a, busy_a, done_a);
        end
        n_checks++;
        if ({req_b, size_b, addr_b, busy_b, done_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got req=%b size=%0d addr=%h busy=%b done=%b expected all 0",
                     req_b, size_b, addr_b, busy_b, done_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_cfg(32'h1000, 40, 32'h400, 2);
        push_basic();
        run_tile("basic", 100, 0, 0);
    endtask

    task automatic test_boundary();
        set_cfg(32'h0FF0, 10, 32'h0, 1);
        exp_q.push_back({32'h0000_0FF0, 10'd2});
        exp_q.push_back({32'h0000_1000, 10'd8});
        run_tile("boundary", 100, 0, 0);
    endtask

    task automatic test_backpressure();
        set_cfg(32'h1000, 40, 32'h400, 2);
        push_basic();
        run_tile("backpressure", 30, 0, 0);
    endtask

    task automatic test_empty();
        set_cfg(32'h2000, 8, 32'h100, 0);
        run_tile("empty_rows", 100, 0, 0);
        set_cfg(32'h2000, 0, 32'h100, 3);
        run_tile("empty_words", 100, 0, 0);
    endtask

    task automatic test_mid_start();
        set_cfg(32'h1000, 40, 32'h400, 2);
        push_basic();
        run_tile("mid_start", 100, 1, 0);
    endtask

    task automatic test_reset_mid();
        set_cfg(32'h1000, 40, 32'h400, 2);
        push_basic();
        run_tile("reset_mid", 100, 0, 2);
        reset    = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (req_a !== 1'b0 || busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid idle: got req=%b busy=%b expected 0 0", req_a, busy_a);
            end
            reset = 1'b0;
            @(negedge clk);
        end
        exp_q.delete();
        set_cfg(32'h1000, 40, 32'h400, 2);
        push_basic();
        run_tile("after_reset", 100, 0, 0);
    endtask

    task automatic test_max_burst();
        sel_b = 1'b1;
        set_cfg(32'h0, 600, 32'h0, 1);
        exp_q.push_back({32'h0000_0000, 10'd512});
        exp_q.push_back({32'h0000_1000, 10'd88});
        run_tile("max_burst", 100, 0, 0);
        sel_b = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic [31:0] base, stride;
            int rw, rows, pct;
            if (it % 2 == 0)
                base = 32'h1000 * $urandom_range(0, 7) + 8 * $urandom_range(440, 511);
            else
                base = $urandom() & 32'hFFFF_FFF8;
            stride = 8 * $urandom_range(0, 1024);
            rw     = $urandom_range(1, 70);
            rows   = $urandom_range(1, 3);
            pct    = $urandom_range(30, 100);
            set_cfg(base, rw, stride, rows);
            model_tile(base, rw, stride, rows, 16);
            run_tile($sformatf("random%0d", it), pct, 0, 0);
        end
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel_b = 1'b0; rd_ready = 1'b0;
        set_cfg(32'h0, 0, 32'h0, 0);
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_empty();
        test_mid_start();
        test_reset_mid();
        test_max_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_rd_req_gen.md
# axi_rd_req_gen

Read-request generator that sits directly upstream of the AXI master wrapper's read port (rd_req / rd_ready / rd_req_size / rd_addr). It takes a strided 2-D tile descriptor from the layer controller and turns it into a sequence of word-aligned read requests. Each request is clipped to a maximum burst length and never crosses a 4 KB boundary. Requests are presented one at a time under a valid/ready handshake. A done pulse is issued after the last request has been accepted.

## Interface
- AXI_DATA_W, 64, AXI data width in bits; one "word" = AXI_DATA_W/8 bytes (WORD_BYTES, power of two)
- ADDR_W, 32, byte address width
- TX_SIZE_WIDTH, 10, width of rd_req_size (units: words)
- MAX_BURST_WORDS, 16, upper bound on any single rd_req_size; 1 ≤ value < 2^TX_SIZE_WIDTH
- CNT_W, 16, width of row count and row-length fields

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cfg_start  in  1  one-cycle start strobe; sampled only in IDLE
- cfg_base_addr  in  ADDR_W  byte address of row 0; WORD_BYTES-aligned
- cfg_row_words  in  CNT_W  words per row
- cfg_stride  in  ADDR_W  byte distance between row starts; WORD_BYTES-aligned
- cfg_num_rows  in  CNT_W  number of rows
- busy  out  1  high from the cycle after accepted start until the done cycle (inclusive)
- done  out  1  one-cycle pulse when the tile has completed
- rd_req  out  1  request valid
- rd_ready  in  1  downstream accept; a transfer occurs when rd_req && rd_ready
- rd_req_size  out  TX_SIZE_WIDTH  words in this request, 1..MAX_BURST_WORDS
- rd_addr  out  ADDR_W  byte start address of this request

## Operation
- Descriptor fields are latched on the start cycle. cfg_* changes afterwards are ignored until the next start.
- FSM states:
  - IDLE: busy=0. On cfg_start, go to CALC.
  - CALC: compute the first chunk, then go to REQ. If num_rows==0 or row_words==0, go to DONE instead.
  - REQ: rd_req=1 with registered addr/size.
  - DONE: done=1, then go to IDLE.
- Chunk size = min(row_rem, MAX_BURST_WORDS, (4096 − addr[11:0]) / WORD_BYTES).
  - Compute at ≥ TX_SIZE_WIDTH+1 bits; no truncation before the min.
- On accept in REQ:
  - row_rem -= size and addr += size*WORD_BYTES.
  - If row_rem reaches 0: row_idx++, row_start += stride, addr = row_start, row_rem = row_words.
  - If that was the last row, go to DONE; otherwise stay in REQ with the next chunk.
- Address arithmetic wraps modulo 2^ADDR_W; no overflow detection.
- rd_addr, rd_req_size and rd_req hold stable while rd_req && !rd_ready. Stall length is unbounded.
- cfg_start while busy is ignored, with no side effects.
- Reset at any point: state=IDLE, all counters cleared, and no further requests are issued.
- Reset values: rd_req=0, rd_req_size=0, rd_addr=0, busy=0, done=0.

## Timing
- Start cycle T: CALC at T+1. First rd_req is visible at T+2 (two-cycle start latency).
- Back-to-back: if rd_ready is held high, one request is accepted every cycle and rd_req never drops within a tile.
  - The next chunk's addr/size are valid the cycle after the previous accept.
- done asserts the cycle after the final accept, with rd_req=0 in that cycle. busy falls the cycle after done.
- Empty descriptor: done at T+2, and rd_req never asserts.
- A new cfg_start is accepted in the cycle after done, since the FSM is already back in IDLE.
- All outputs are registered; there is no combinational path from rd_ready to any output.

## Test plan
- Basic strided tile: base=0x1000, row_words=40, stride=0x400, rows=2, rd_ready=1.
  - Required requests, in order: (0x1000,16), (0x1080,16), (0x1100,8), (0x1400,16), (0x1480,16), (0x1500,8).
  - Exactly 6 accepts, then done one cycle after the last.
- 4 KB boundary split: base=0x0FF0, row_words=10, rows=1.
  - Required requests: (0x0FF0,2), (0x1000,8), then done.
- Backpressure: same descriptor as the basic tile, with rd_ready toggling randomly (~30% high).
  - addr and size stay constant during every stall.
  - The sequence is identical to the basic-tile sequence, with no dropped or duplicated requests.
- Empty and ignored starts:
  - rows=0 → done at T+2, no rd_req.
  - row_words=0 → same result.
  - cfg_start pulsed mid-tile → no effect on the sequence, and no extra done.
- Reset mid-tile: assert reset after the 2nd accept of the basic tile.
  - rd_req=0 and busy=0 from the next cycle.
  - A fresh start then reproduces the full 6-request sequence from 0x1000.
- Max burst / width limit: MAX_BURST_WORDS=1023, base=0x0, row_words=600, WORD_BYTES=8.
  - Required requests: (0x0,512), (0x1000,88), limited by the 4 KB boundary, with no size truncation.
